power_result_collector: RTL

//  Receiving end of the power pipeline's output stream (o_valid/o_data).

---
 rtl/power_result_collector.sv | 137 +++++++++++++
 1 files changed

// File: rtl/power_result_collector.sv
// power_result_collector
//  Receives the power pipeline's result stream, buffers it in a small FIFO
//  and hands results to a downstream consumer over valid/ready. It counts
//  accepted results (saturating) and raises a sticky flag on drops.
//  Upstream cannot be stalled, so a full FIFO with no pop drops the input.
//
//  Optional build macro: POWER_COLLECT_SUM_EN
//    When defined, adds o_sum, the running modulo-2^DATA_WIDTH sum of all
//    accepted results. When undefined, neither the port nor the adder exist.
module power_result_collector #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_overflow
`ifdef POWER_COLLECT_SUM_EN
    ,
    output logic [DATA_WIDTH-1:0] o_sum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] OCC_ZERO = '0;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    // Pointer advance; natural wrap DEPTH-1 -> 0 since DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr_n;
    logic [PTR_W-1:0]      rd_ptr_n;
    logic [PTR_W:0]        occ;
    logic [PTR_W:0]        occ_n;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [DATA_WIDTH-1:0] head_n;

    // The head is visible whenever anything is stored.
    assign o_valid = !o_empty;

    // Next-state: handshake decode, pointer/occupancy update and next head value.
    always_comb begin
        pop      = o_valid && o_ready;
        // A pop in the same edge frees a slot, so a full FIFO still accepts.
        push     = i_valid && (!o_full || pop);
        drop     = i_valid && o_full && !pop;
        wr_ptr_n = push ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_n = pop  ? ptr_inc(rd_ptr) : rd_ptr;

        occ_n = occ;
        case ({push, pop})
            2'b10:   occ_n = occ + (PTR_W + 1)'(1);
            2'b01:   occ_n = occ - (PTR_W + 1)'(1);
            default: occ_n = occ;
        endcase

        // o_data is registered, so the post-edge head is computed here. When
        // the new head slot is the one being written this edge (FIFO empty,
        // or last entry popped while pushing), the array has not been updated
        // yet and the incoming word is forwarded into the output register.
        head_n = '0;
        if (occ_n == OCC_ZERO) begin
            head_n = '0;
        end else if (push && (wr_ptr == rd_ptr_n)) begin
            head_n = i_data;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    // Storage array: data only, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Control and registered status/outputs; reset discards all stored entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            o_empty    <= 1'b1;
            o_full     <= 1'b0;
            o_data     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            occ        <= occ_n;
            o_empty    <= (occ_n == OCC_ZERO);
            o_full     <= (occ_n == OCC_FULL);
            o_data     <= head_n;
            o_overflow <= o_overflow | drop;
            if (push) begin
                o_count <= sat_inc(o_count);
            end
        end
    end

`ifdef POWER_COLLECT_SUM_EN
    // Running sum of accepted results; dropped inputs never reach the adder.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_sum <= '0;
        end else if (push) begin
            o_sum <= o_sum + i_data;
        end
    end
`endif

endmodule
